fft_frame_feeder: RTL

Source side of the FFT datapath: takes raw ADC samples on `fft_clk`, decimates them, buffers them in a small FIFO and streams fixed-length frames into the FFT core's AXI-Stream slave data port with correct `tlast` framing. Before each run it also sends a one-shot forward-transform configuration word on the FFT config channel. Its output frames are what the downstream modulus/peak-search logic later consumes.

---
 rtl/fft_frame_feeder.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder
//
// Source side of the FFT datapath. Decimates raw ADC samples, buffers them in a
// small registered FIFO and streams fixed-length frames (with tlast) into the
// FFT core's AXI-Stream data port. Each run starts with a single forward-transform
// configuration word on the FFT config channel.
//
// Ports:
//   fft_clk, rst               clock, synchronous active-high reset
//   ad_data, ad_valid          ADC sample and one-cycle strobe
//   start                      begin a run (honoured only when idle)
//   s_axis_config_*            config word channel (tdata fixed at 8'h01)
//   s_axis_data_*              frame data stream, {16'h0000, real[15:0]}, tlast on last beat
//   busy                       high while configuring, capturing or draining
//   frame_done                 one-cycle pulse after each tlast handshake
//   ovf                        sticky sample-dropped flag, cleared by an accepted start

module fft_frame_feeder #(
    parameter int unsigned FFT_LEN     = 4096,
    parameter int unsigned DECIM       = 8,
    parameter int unsigned ADW         = 10,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned SIGNED_CONV = 0,
    parameter int unsigned CONTINUOUS  = 0
) (
    input  logic            fft_clk,
    input  logic            rst,
    input  logic [ADW-1:0]  ad_data,
    input  logic            ad_valid,
    input  logic            start,
    output logic [7:0]      s_axis_config_tdata,
    output logic            s_axis_config_tvalid,
    input  logic            s_axis_config_tready,
    output logic [31:0]     s_axis_data_tdata,
    output logic            s_axis_data_tvalid,
    input  logic            s_axis_data_tready,
    output logic            s_axis_data_tlast,
    output logic            busy,
    output logic            frame_done,
    output logic            ovf
);

    localparam int unsigned LW = $clog2(FFT_LEN);
    localparam int unsigned DW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    localparam logic [LW-1:0] LEN_LAST  = LW'(FFT_LEN - 1);
    localparam logic [DW-1:0] DEC_LAST  = DW'(DECIM - 1);
    localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StCfg, StRun, StDrain} state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   dec_cnt_q, dec_cnt_d;
    logic [LW-1:0]   in_cnt_q, in_cnt_d;
    logic [LW-1:0]   out_cnt_q, out_cnt_d;
    logic            ovf_q, ovf_d;
    logic            frame_done_q;

    logic [ADW-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;

    logic            fifo_empty, fifo_full;
    logic            pop, last_hs, take, push, drop;
    logic [ADW-1:0]  head;
    logic [15:0]     sample_real;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FIFO_FULL);

    assign pop     = !fifo_empty && s_axis_data_tready;
    assign last_hs = pop && (out_cnt_q == LEN_LAST);

    // A decimated sample is due; it is dropped only if the FIFO stays full this cycle.
    assign take = (state_q == StRun) && ad_valid && (dec_cnt_q == DEC_LAST);
    assign push = take && (!fifo_full || pop);
    assign drop = take && fifo_full && !pop;

    // Next-state logic for the run FSM and capture counters.
    always_comb begin
        state_d   = state_q;
        dec_cnt_d = dec_cnt_q;
        in_cnt_d  = in_cnt_q;
        ovf_d     = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StCfg;
                    ovf_d   = 1'b0;
                end
            end
            StCfg: begin
                if (s_axis_config_tready) begin
                    state_d   = StRun;
                    dec_cnt_d = '0;
                    in_cnt_d  = '0;
                end
            end
            StRun: begin
                if (ad_valid) begin
                    dec_cnt_d = (dec_cnt_q == DEC_LAST) ? '0 : dec_cnt_q + 1'b1;
                end
                if (push) begin
                    // Only accepted samples count, so a frame always has FFT_LEN beats.
                    in_cnt_d = in_cnt_q + 1'b1;
                    if (in_cnt_q == LEN_LAST) begin
                        state_d = StDrain;
                    end
                end
                if (drop) begin
                    ovf_d = 1'b1;
                end
            end
            StDrain: begin
                if (last_hs) begin
                    state_d   = (CONTINUOUS != 0) ? StRun : StIdle;
                    dec_cnt_d = '0;
                    in_cnt_d  = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        out_cnt_d = out_cnt_q;
        if (last_hs) begin
            out_cnt_d = '0;
        end else if (pop) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge fft_clk) begin
        if (rst) begin
            state_q      <= StIdle;
            dec_cnt_q    <= '0;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            ovf_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dec_cnt_q    <= dec_cnt_d;
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
            ovf_q        <= ovf_d;
            frame_done_q <= last_hs;
        end
    end

    // FIFO pointers and occupancy; storage itself needs no reset.
    always_ff @(posedge fft_clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge fft_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ad_data;
        end
    end

    // Offset-binary to two's complement is an MSB flip followed by sign extension.
    always_comb begin
        head = mem_q[rd_ptr_q];
        if (SIGNED_CONV != 0) begin
            head[ADW-1] = ~head[ADW-1];
        end
        sample_real = (SIGNED_CONV != 0) ? 16'($signed(head)) : 16'(head);
    end

    assign s_axis_config_tdata  = 8'h01;
    assign s_axis_config_tvalid = (state_q == StCfg);
    assign s_axis_data_tvalid   = !fifo_empty;
    assign s_axis_data_tdata    = fifo_empty ? 32'h0 : {16'h0000, sample_real};
    assign s_axis_data_tlast    = !fifo_empty && (out_cnt_q == LEN_LAST);
    assign busy                 = (state_q != StIdle);
    assign frame_done           = frame_done_q;
    assign ovf                  = ovf_q;

endmodule
